// File: rtl/uart_bus_bridge_pkg.sv
// Shared opcodes, reply codes and frame-FSM state encoding for the UART-to-bus bridge.
package uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OP,
    ST_W_ADDR,
    ST_W_HI,
    ST_W_LO,
    ST_BUS_WR,
    ST_R_ADDR,
    ST_BUS_RD,
    ST_SEND,
    ST_SEND_WAIT
  } bridge_state_e;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Device control bus: 8-bit address, 16-bit data, single-cycle strobe.
interface uart_bus_bridge_if;
  logic        bus_control;
  logic        bus_write_enable;
  logic [7:0]  bus_address;
  logic [15:0] bus_data_out;
  logic [15:0] bus_data_in;

  modport master (
    output bus_control, bus_write_enable, bus_address, bus_data_out,
    input  bus_data_in
  );

  modport slave (
    input  bus_control, bus_write_enable, bus_address, bus_data_out,
    output bus_data_in
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver; holds one byte with a data_ready flag cleared by read_en.
module uart_rx #(
  parameter logic [15:0] BAUD_DIVIDER = 16'h8C
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       read_en,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       overrun
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  localparam logic [15:0] HALF_BIT = BAUD_DIVIDER >> 1;

  rx_state_e   state, next_state;
  logic [1:0]  sync;
  logic        rx_s;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_end, half_end, byte_done;

  assign rx_s     = sync[1];
  assign bit_end  = (baud_cnt == BAUD_DIVIDER - 16'd1);
  assign half_end = (baud_cnt == HALF_BIT - 16'd1);

  always_comb begin
    next_state = state;
    byte_done  = 1'b0;
    case (state)
      RX_IDLE:  if (!rx_s) next_state = RX_START;
      RX_START: if (half_end) next_state = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_idx == 3'd7) next_state = RX_STOP;
      RX_STOP: begin
        if (bit_end) begin
          next_state = RX_IDLE;
          byte_done  = rx_s;
        end
      end
      default:  next_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RX_IDLE;
      sync       <= '1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= next_state;
      sync  <= {sync[0], rx};
      if (state == RX_IDLE || next_state != state || bit_end)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 16'd1;
      if (state == RX_IDLE)
        bit_idx <= '0;
      else if (state == RX_DATA && bit_end) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      // A byte completing in the same cycle as read_en wins: the reader took the old one.
      if (byte_done) begin
        data_out   <= shreg;
        data_ready <= 1'b1;
        overrun    <= data_ready & ~read_en;
      end else if (read_en) begin
        data_ready <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; data_ready is high while idle and able to take a byte.
module uart_tx #(
  parameter logic [15:0] BAUD_DIVIDER = 16'h8C
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       write_en,
  output logic       data_ready,
  output logic       tx
);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;

  tx_state_e   state, next_state;
  logic [9:0]  shreg;
  logic [3:0]  bit_cnt;
  logic [15:0] baud_cnt;
  logic        bit_end;

  assign bit_end    = (baud_cnt == BAUD_DIVIDER - 16'd1);
  assign data_ready = (state == TX_IDLE);
  assign tx         = shreg[0];

  always_comb begin
    next_state = state;
    case (state)
      TX_IDLE:  if (write_en) next_state = TX_SHIFT;
      TX_SHIFT: if (bit_end && bit_cnt == 4'd9) next_state = TX_IDLE;
      default:  next_state = TX_IDLE;
    endcase
  end

  // Shifting in ones leaves the register all-ones after the stop bit, so tx idles high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= TX_IDLE;
      shreg    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == TX_IDLE) begin
        if (write_en) begin
          shreg    <= {1'b1, data_in, 1'b0};
          bit_cnt  <= '0;
          baud_cnt <= '0;
        end
      end else if (bit_end) begin
        shreg    <= {1'b1, shreg[9:1]};
        bit_cnt  <= bit_cnt + 4'd1;
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command frames to single-cycle control-bus reads/writes, replies on tx.
// UART_BRIDGE_TIMEOUT_EN builds an inter-byte gap counter that aborts partial frames.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter logic [15:0] BAUD_DIVIDER   = 16'h8C,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      rx,
  output logic                      tx,
  output logic                      busy,
  uart_bus_bridge_if.master         bus
);

  bridge_state_e state, next_state;

  logic [7:0]  rx_data;
  logic        rx_ready, rx_read_en, rx_overrun_unused;
  logic [7:0]  tx_byte;
  logic        tx_ready, tx_write_en;

  logic [7:0]  op_byte;
  logic [7:0]  addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  reply [2];
  logic        reply_two, reply_idx, tx_fell;
  logic        load_nak, gap_expired;

  uart_rx #(.BAUD_DIVIDER(BAUD_DIVIDER)) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .read_en    (rx_read_en),
    .data_out   (rx_data),
    .data_ready (rx_ready),
    .overrun    (rx_overrun_unused)
  );

  uart_tx #(.BAUD_DIVIDER(BAUD_DIVIDER)) u_tx (
    .clock      (clock),
    .reset_n    (reset_n),
    .data_in    (tx_byte),
    .write_en   (tx_write_en),
    .data_ready (tx_ready),
    .tx         (tx)
  );

  assign bus.bus_control      = (state == ST_BUS_WR) || (state == ST_BUS_RD);
  assign bus.bus_write_enable = (state == ST_BUS_WR);
  assign bus.bus_address      = addr_q;
  assign bus.bus_data_out     = wdata_q;
  assign busy                 = (state != ST_IDLE);
  assign tx_byte              = reply[reply_idx];

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [23:0] gap_cnt;
  logic        in_gap;

  assign in_gap      = state inside {ST_W_ADDR, ST_W_HI, ST_W_LO, ST_R_ADDR};
  assign gap_expired = in_gap && (gap_cnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      gap_cnt <= '0;
    else if (in_gap && !rx_read_en)
      gap_cnt <= gap_cnt + 24'd1;
    else
      gap_cnt <= '0;
  end
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT_CYCLES;
  assign gap_expired    = 1'b0;
`endif

  always_comb begin
    next_state  = state;
    rx_read_en  = 1'b0;
    tx_write_en = 1'b0;
    load_nak    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_ready) begin
          rx_read_en = 1'b1;
          next_state = ST_OP;
        end
      end
      ST_OP: begin
        if (op_byte == OP_WRITE)     next_state = ST_W_ADDR;
        else if (op_byte == OP_READ) next_state = ST_R_ADDR;
        else begin
          load_nak   = 1'b1;
          next_state = ST_SEND;
        end
      end
      ST_W_ADDR, ST_W_HI, ST_W_LO, ST_R_ADDR: begin
        if (rx_ready) begin
          rx_read_en = 1'b1;
          case (state)
            ST_W_ADDR: next_state = ST_W_HI;
            ST_W_HI:   next_state = ST_W_LO;
            ST_W_LO:   next_state = ST_BUS_WR;
            default:   next_state = ST_BUS_RD;
          endcase
        end else if (gap_expired) begin
          load_nak   = 1'b1;
          next_state = ST_SEND;
        end
      end
      ST_BUS_WR, ST_BUS_RD: next_state = ST_SEND;
      ST_SEND: begin
        if (tx_ready) begin
          tx_write_en = 1'b1;
          next_state  = ST_SEND_WAIT;
        end
      end
      ST_SEND_WAIT: begin
        if (tx_fell && tx_ready)
          next_state = (reply_two && !reply_idx) ? ST_SEND : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op_byte   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      reply[0]  <= '0;
      reply[1]  <= '0;
      reply_two <= 1'b0;
      reply_idx <= 1'b0;
      tx_fell   <= 1'b0;
    end else begin
      state <= next_state;
      if (rx_read_en) begin
        case (state)
          ST_IDLE:              op_byte       <= rx_data;
          ST_W_ADDR, ST_R_ADDR: addr_q        <= rx_data;
          ST_W_HI:              wdata_q[15:8] <= rx_data;
          ST_W_LO:              wdata_q[7:0]  <= rx_data;
          default: ;
        endcase
      end
      if (load_nak || state == ST_BUS_WR) begin
        reply[0]  <= load_nak ? RSP_NAK : RSP_ACK;
        reply_two <= 1'b0;
        reply_idx <= 1'b0;
      end else if (state == ST_BUS_RD) begin
        reply[0]  <= bus.bus_data_in[15:8];
        reply[1]  <= bus.bus_data_in[7:0];
        reply_two <= 1'b1;
        reply_idx <= 1'b0;
      end else if (state == ST_SEND_WAIT && tx_fell && tx_ready) begin
        reply_idx <= 1'b1;
      end
      // Only a ready rise seen after the fall marks the byte as fully shifted out.
      if (tx_write_en)
        tx_fell <= 1'b0;
      else if (state == ST_SEND_WAIT && !tx_ready)
        tx_fell <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: frame table, serial scoreboard, corner sequences.
module tb_uart_bus_bridge;
  import uart_bridge_pkg::*;

  localparam int unsigned BAUD = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic rx      = 1'b1;
  logic tx, busy;
  logic [15:0] mem [256];

  uart_bus_bridge_if bus_if();
  assign bus_if.bus_data_in = mem[bus_if.bus_address];

  uart_bus_bridge #(
    .BAUD_DIVIDER   (16'd16),
    .TIMEOUT_CYCLES (24'd1000)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rx      (rx),
    .tx      (tx),
    .busy    (busy),
    .bus     (bus_if.master)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
  } bus_exp_t;

  typedef struct {
    int unsigned n_rx;
    logic [31:0] rx_bytes;
    bit          strobe;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
    int unsigned n_rep;
    logic [15:0] rep;
    string       name;
  } vec_t;

  bus_exp_t   bus_q[$];
  logic [7:0] rep_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Device model: strobes are checked against the queue, writes land in mem.
  initial begin
    bus_exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && bus_if.bus_control) begin
        if (bus_q.size() == 0) begin
          check("strobe expected", bus_q.size(), 1);
        end else begin
          e = bus_q.pop_front();
          check("strobe we", bus_if.bus_write_enable, e.we);
          check("strobe addr", bus_if.bus_address, e.addr);
          if (e.we) check("strobe wdata", bus_if.bus_data_out, e.data);
        end
        if (bus_if.bus_write_enable) mem[bus_if.bus_address] = bus_if.bus_data_out;
      end
    end
  end

  // Serial receiver on tx: decodes each byte and pops the expected reply.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (BAUD / 2) @(negedge clock);
      check("tx start bit", tx, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clock);
        b[i] = tx;
      end
      check("busy during reply", busy, 1);
      if (rep_q.size() == 0) check("reply expected", rep_q.size(), 1);
      else                   check("reply byte", b, rep_q.pop_front());
      repeat (BAUD) @(negedge clock);
      check("tx stop bit", tx, 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (BAUD) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clock);
    end
    rx = 1'b1;
    repeat (BAUD) @(negedge clock);
  endtask

  task automatic wait_done(input string name, input int unsigned limit);
    bit done = 1'b0;
    for (int unsigned c = 0; c < limit && !done; c++) begin
      @(negedge clock);
      done = (rep_q.size() == 0 && bus_q.size() == 0 && !busy);
    end
    check({name, " done"}, done, 1);
    repeat (BAUD) @(negedge clock);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.strobe) bus_q.push_back({v.we, v.addr, v.data});
    if (v.n_rep == 2) begin
      rep_q.push_back(v.rep[15:8]);
      rep_q.push_back(v.rep[7:0]);
    end else if (v.n_rep == 1) begin
      rep_q.push_back(v.rep[7:0]);
    end
    for (int unsigned k = 0; k < v.n_rx; k++) send_byte(v.rx_bytes[31 - 8*k -: 8]);
    wait_done(v.name, 60 * BAUD);
    if (v.strobe) check({v.name, " addr held"}, bus_if.bus_address, v.addr);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("reset busy", busy, 0);
    check("reset control", bus_if.bus_control, 0);
    check("reset addr", bus_if.bus_address, 0);
    check("reset wdata", bus_if.bus_data_out, 0);
    check("reset tx", tx, 1);
    reset_n = 1'b1;
    repeat (4 * BAUD) @(negedge clock);
  endtask

  vec_t vecs [10];
  vec_t rd_ff, rd_02;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'hA55A;
    mem[1] = 16'h1304;

    vecs[0] = '{4, 32'h5702008C, 1'b1, 1'b1, 8'h02, 16'h008C, 1, 16'h0006, "write 02"};
    vecs[1] = '{2, 32'h52010000, 1'b1, 1'b0, 8'h01, 16'h0000, 2, 16'h1304, "read 01"};
    vecs[2] = '{1, 32'h41000000, 1'b0, 1'b0, 8'h00, 16'h0000, 1, 16'h0015, "bad 41"};
    vecs[3] = '{2, 32'h52000000, 1'b1, 1'b0, 8'h00, 16'h0000, 2, 16'hA55A, "read 00"};
    vecs[4] = '{2, 32'h52020000, 1'b1, 1'b0, 8'h02, 16'h0000, 2, 16'h008C, "read 02"};
    vecs[5] = '{4, 32'h57FFFFFF, 1'b1, 1'b1, 8'hFF, 16'hFFFF, 1, 16'h0006, "write FF"};
    vecs[6] = '{2, 32'h52FF0000, 1'b1, 1'b0, 8'hFF, 16'h0000, 2, 16'hFFFF, "read FF"};
    vecs[7] = '{1, 32'hFF000000, 1'b0, 1'b0, 8'h00, 16'h0000, 1, 16'h0015, "bad FF"};
    vecs[8] = '{4, 32'h57000000, 1'b1, 1'b1, 8'h00, 16'h0000, 1, 16'h0006, "write 00"};
    vecs[9] = '{2, 32'h52000000, 1'b1, 1'b0, 8'h00, 16'h0000, 2, 16'h0000, "read 00 zero"};
    rd_ff   = '{2, 32'h52FF0000, 1'b1, 1'b0, 8'hFF, 16'h0000, 2, 16'hFFFF, "read after reset"};
    rd_02   = '{2, 32'h52020000, 1'b1, 1'b0, 8'h02, 16'h0000, 2, 16'h008C, "read after stall"};

    repeat (3) @(negedge clock);
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset control", bus_if.bus_control, 0);
    check("reset we", bus_if.bus_write_enable, 0);
    check("reset addr", bus_if.bus_address, 0);
    check("reset wdata", bus_if.bus_data_out, 0);
    reset_n = 1'b1;
    repeat (4 * BAUD) @(negedge clock);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Back-to-back frames: the read opcode arrives while the ACK is still shifting out.
    bus_q.push_back({1'b1, 8'h10, 16'hABCD});
    rep_q.push_back(RSP_ACK);
    bus_q.push_back({1'b0, 8'h10, 16'h0000});
    rep_q.push_back(8'hAB);
    rep_q.push_back(8'hCD);
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hAB);
    send_byte(8'hCD); send_byte(8'h52); send_byte(8'h10);
    wait_done("back to back", 80 * BAUD);

    // Reset while waiting for the write data high byte.
    send_byte(8'h57);
    send_byte(8'h05);
    repeat (20) @(negedge clock);
    check("mid frame busy", busy, 1);
    check("mid frame addr", bus_if.bus_address, 8'h05);
    reset_pulse();
    check("no strobe after abort", bus_q.size(), 0);
    run_vec(rd_ff);

    // Partial frame followed by silence.
    send_byte(8'h57);
    send_byte(8'h05);
`ifdef UART_BRIDGE_TIMEOUT_EN
    rep_q.push_back(RSP_NAK);
    wait_done("timeout nak", 1000 + 40 * BAUD);
`else
    repeat (3000) @(negedge clock);
    check("stalled frame busy", busy, 1);
    check("stalled frame tx idle", tx, 1);
    reset_pulse();
`endif
    run_vec(rd_02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
Serial-to-bus initiator: the host end of the device control bus, driven from a UART link. It receives command frames on rx, issues single-cycle reads and writes on the 8-bit-address / 16-bit-data control bus, and returns replies on tx. It sits between the external debug/loader UART pins and the device bus, so a host PC can poke any device's control registers.

Parameters:
BAUD_DIVIDER, 16'h8C, clock cycles per bit (115200 baud); fixed, not software-writable.
TIMEOUT_CYCLES, 24'd1_000_000, inter-byte gap limit; used only with UART_BRIDGE_TIMEOUT_EN.

Ports:
clock  input  1  system clock; all logic on posedge.
reset_n  input  1  asynchronous, active-low reset.
rx  input  1  serial in; idles high.
tx  output  1  serial out; idles high.
bus_control  output  1  high for exactly one cycle per bus access.
bus_write_enable  output  1  high with bus_control for writes only.
bus_address  output  8  register address; held from frame decode until the next frame.
bus_data_out  output  16  write data to device (device data_in).
bus_data_in  input  16  read data from device (device data_out); combinational, same cycle.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values while reset_n=0: FSM in IDLE; bus_control=0, bus_write_enable=0, bus_address=0, bus_data_out=0, busy=0; no tx byte enqueued; tx=1.
- Reset asserted mid-frame or mid-reply: the partial frame is discarded, no bus access is issued, and any reply byte not yet handed to uart_tx is dropped.
- Byte intake:
  - The FSM consumes a byte when the uart_rx data_ready flag is high.
  - It pulses uart_rx read_en for one cycle in the same cycle it latches data_out.
  - A byte arriving while the FSM is not accepting (busy replying) stays pending in uart_rx. Overrun follows uart_rx semantics.
- Frames:
  - Write: 0x57, addr, data_hi, data_lo. Reply 0x06.
  - Read: 0x52, addr. Reply data_hi, data_lo.
  - Any other first byte: reply 0x15 (NAK), back to IDLE, no bus access.
- States and transitions:
  - IDLE -> OP.
  - OP: 0x57 -> W_ADDR; 0x52 -> R_ADDR; otherwise -> SEND.
  - W_ADDR -> W_HI -> W_LO -> BUS_WR.
  - R_ADDR -> BUS_RD.
  - BUS_WR and BUS_RD each last exactly one cycle, then go to SEND.
  - SEND -> SEND_WAIT -> IDLE.
- Bus access:
  - BUS_WR: bus_control=1 and bus_write_enable=1 for one cycle, with address and data stable in that cycle.
  - BUS_RD: bus_control=1 and bus_write_enable=0 for one cycle; bus_data_in is captured at the end of that cycle.
  - Latency from the last rx byte latched to the bus strobe is 1 cycle.
- Reply:
  - Reply bytes go into a 2-entry reply register; the count is 1 for ACK/NAK and 2 for reads.
  - A byte is written to uart_tx with a one-cycle write_en pulse, only when uart_tx data_ready=1.
  - The FSM waits for data_ready to fall and rise again before sending the next byte.
  - IDLE is re-entered only after the last byte is accepted.
- Byte order is big-endian: hi byte first.

Optional Feature:
UART_BRIDGE_TIMEOUT_EN:
- Defined:
  - A 24-bit gap counter runs in W_ADDR, W_HI, W_LO and R_ADDR.
  - It clears on every byte consumed.
  - When it reaches TIMEOUT_CYCLES-1, the frame is aborted: no bus access, 0x15 is sent, then IDLE.
- Undefined: no counter is built, and a partial frame waits forever.

Decomposition:
- Package uart_bridge_pkg holds:
  - the opcodes 0x57 and 0x52;
  - the response codes 0x06 and 0x15;
  - the FSM state enum.
- Byte transport reuses the existing uart_rx and uart_tx, both clocked by BAUD_DIVIDER.
- No new sub-module; the frame FSM plus reply register is roughly 200 lines.

Test Plan:
- Write frame: serial 57 02 00 8C -> exactly one cycle with bus_control=1, bus_write_enable=1, bus_address=02, bus_data_out=008C; tx returns 06.
- Read frame: 52 01 with bus_data_in=1304 -> one strobe with bus_write_enable=0 and bus_address=01; tx returns 13 then 04; busy falls after the stop bit of 04.
- Bad opcode: 41 -> tx returns 15; zero bus strobes; next frame 52 00 succeeds.
- Back-to-back frames: 57 10 AB CD 52 10 sent with no idle gap -> write then read in order; replies 06, AB, CD (with the model echoing the written data).
- Reset pulse during W_HI of a write -> no strobe, no reply; the following 52 00 works normally.
- With UART_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=1000: 57 05 then silence -> 15 returned after 1000 cycles, no strobe; without the macro, nothing is returned.
